instruction_fetch: RTL and testbench

- Upstream stage of instruction_mux.
- Fetches 32-bit RISC-V instruction words from instruction memory over a single-outstanding req/ack handshake and holds them in a small prefetch FIFO.
- Presents the head word as oIR, its opcode field as oOPCODE and its address as oPC to the decode/execute path.
- Accepts a redirect from downstream for branches and jumps; a redirect flushes buffered words and restarts fetch at the new PC.

---
 rtl/instruction_fetch.sv | 166 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues single-outstanding requests to instruction
// memory, buffers returned words with their addresses in a small prefetch
// FIFO, and hands the head word to decode. A redirect flushes the FIFO and
// restarts fetch at the new target; a request already on the bus is allowed
// to complete (its data is thrown away) before the target is fetched.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    output logic        oIMEM_REQ,
    output logic [31:0] oIMEM_ADDR,
    input  logic        iIMEM_ACK,
    input  logic [31:0] iIMEM_RDATA,
    input  logic        iREDIRECT,
    input  logic [31:0] iREDIRECT_PC,
    output logic        oIR_VALID,
    output logic [31:0] oIR,
    output logic [6:0]  oOPCODE,
    output logic [31:0] oPC,
    input  logic        iIR_READY
);

    localparam int             AW         = $clog2(DEPTH);
    localparam int             CW         = AW + 1;
    localparam logic [CW-1:0]  DEPTH_C    = CW'(DEPTH);
    localparam logic [31:0]    RESET_PC_A = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q;
    logic            req_q;
    logic [31:0]     fetch_pc_q;
    logic [31:0]     target_pc_q;

    logic [31:0]     pc_mem_q [DEPTH];
    logic [31:0]     ir_mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            empty;
    logic            push;
    logic            pop;
    logic [31:0]     redir_pc;
    logic [CW-1:0]   count_after_push;
    logic            unused_redir_lsbs;

    assign redir_pc          = {iREDIRECT_PC[31:2], 2'b00};
    assign unused_redir_lsbs = ^iREDIRECT_PC[1:0];

    // A redirect voids both the push of an arriving word and any pop.
    assign empty = (count_q == '0);
    assign push  = (state_q == REQ) && iIMEM_ACK && !iREDIRECT;
    assign pop   = !empty && iIR_READY && !iREDIRECT;

    // Occupancy after this cycle's push, including a same-cycle pop; decides
    // whether the next request can be issued back-to-back.
    assign count_after_push = count_q + CW'(1) - {{(CW-1){1'b0}}, pop};

    // FIFO pointer/occupancy next-state; a redirect empties the FIFO.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (iREDIRECT) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO control registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are only observed through a valid head.
    always_ff @(posedge iCLK) begin
        if (push) begin
            pc_mem_q[wr_ptr_q] <= fetch_pc_q;
            ir_mem_q[wr_ptr_q] <= iIMEM_RDATA;
        end
    end

    // Fetch FSM: request sequencing, redirect handling and bus drain.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            fetch_pc_q  <= RESET_PC_A;
            target_pc_q <= RESET_PC_A;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iREDIRECT) begin
                        state_q    <= REQ;
                        req_q      <= 1'b1;
                        fetch_pc_q <= redir_pc;
                    end else if (count_q < DEPTH_C) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                    end
                end
                REQ: begin
                    if (iIMEM_ACK) begin
                        if (iREDIRECT) begin
                            fetch_pc_q <= redir_pc;
                        end else begin
                            fetch_pc_q <= fetch_pc_q + 32'd4;
                            if (count_after_push >= DEPTH_C) begin
                                state_q <= IDLE;
                                req_q   <= 1'b0;
                            end
                        end
                    end else if (iREDIRECT) begin
                        // Old request stays on the bus until it is acknowledged.
                        state_q     <= DRAIN;
                        target_pc_q <= redir_pc;
                    end
                end
                DRAIN: begin
                    if (iIMEM_ACK) begin
                        state_q    <= REQ;
                        fetch_pc_q <= iREDIRECT ? redir_pc : target_pc_q;
                    end else if (iREDIRECT) begin
                        target_pc_q <= redir_pc;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign oIMEM_REQ  = req_q;
    assign oIMEM_ADDR = fetch_pc_q;
    assign oIR_VALID  = !empty;
    assign oIR        = empty ? 32'd0 : ir_mem_q[rd_ptr_q];
    assign oPC        = empty ? 32'd0 : pc_mem_q[rd_ptr_q];
    assign oOPCODE    = oIR[6:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch: streaming, back-pressure,
// redirect corner cases, PC wrap and asynchronous reset.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        ir_valid;
    logic [31:0] ir;
    logic [6:0]  opcode;
    logic [31:0] pc;
    logic        ir_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    instruction_fetch #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (2)
    ) dut (
        .iCLK        (clk),
        .iRST_N      (rst_n),
        .oIMEM_REQ   (imem_req),
        .oIMEM_ADDR  (imem_addr),
        .iIMEM_ACK   (imem_ack),
        .iIMEM_RDATA (imem_rdata),
        .iREDIRECT   (redirect),
        .iREDIRECT_PC(redirect_pc),
        .oIR_VALID   (ir_valid),
        .oIR         (ir),
        .oOPCODE     (opcode),
        .oPC         (pc),
        .iIR_READY   (ir_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #10;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b want=0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h want=00000000", imem_addr); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", ir_valid); end
        checks++; if (ir !== 32'h0 || opcode !== 7'h0 || pc !== 32'h0) begin errors++; $display("FAIL rst_head got ir=%h op=%h pc=%h want all 0", ir, opcode, pc); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL first_valid got=%b want=0", ir_valid); end
    endtask

    task automatic test_stream();
        ir_ready = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'h00B5_0533;
        tick();
        checks++; if (ir_valid !== 1'b1 || pc !== 32'h0 || ir !== 32'h00B5_0533) begin errors++; $display("FAIL stream0 got v=%b pc=%h ir=%h want v=1 pc=0 ir=00b50533", ir_valid, pc, ir); end
        checks++; if (opcode !== 7'h33) begin errors++; $display("FAIL stream0_op got=%h want=33", opcode); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL stream0_addr got req=%b addr=%h want 1/4", imem_req, imem_addr); end
        imem_rdata = 32'h00C5_8593;
        tick();
        checks++; if (pc !== 32'h4 || opcode !== 7'h13 || imem_addr !== 32'h8) begin errors++; $display("FAIL stream1 got pc=%h op=%h addr=%h want 4/13/8", pc, opcode, imem_addr); end
        imem_rdata = 32'h0000_006F;
        tick();
        checks++; if (pc !== 32'h8 || opcode !== 7'h6F || imem_addr !== 32'hC) begin errors++; $display("FAIL stream2 got pc=%h op=%h addr=%h want 8/6f/c", pc, opcode, imem_addr); end
        imem_ack = 1'b0;
        tick();
        checks++; if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL stream_end got v=%b req=%b addr=%h want 0/1/c", ir_valid, imem_req, imem_addr); end
    endtask

    task automatic test_backpressure();
        ir_ready = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h1111_1113;
        tick();
        checks++; if (ir_valid !== 1'b1 || pc !== 32'hC || imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL bp_one got v=%b pc=%h req=%b addr=%h want 1/c/1/10", ir_valid, pc, imem_req, imem_addr); end
        imem_rdata = 32'h2222_2233;
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_full_req got=%b want=0", imem_req); end
        imem_ack = 1'b0;
        tick();
        checks++; if (pc !== 32'hC || ir !== 32'h1111_1113 || imem_req !== 1'b0) begin errors++; $display("FAIL bp_stall got pc=%h ir=%h req=%b want c/11111113/0", pc, ir, imem_req); end
        ir_ready = 1'b1;
        tick();
        checks++; if (ir_valid !== 1'b1 || pc !== 32'h10 || ir !== 32'h2222_2233) begin errors++; $display("FAIL bp_order got v=%b pc=%h ir=%h want 1/10/22222233", ir_valid, pc, ir); end
        tick();
        checks++; if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h14) begin errors++; $display("FAIL bp_resume got v=%b req=%b addr=%h want 0/1/14", ir_valid, imem_req, imem_addr); end
    endtask

    task automatic test_redirect_outstanding();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14 || ir_valid !== 1'b0) begin errors++; $display("FAIL drain_hold got req=%b addr=%h v=%b want 1/14/0", imem_req, imem_addr, ir_valid); end
        tick();
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin errors++; $display("FAIL drain_hold2 got req=%b addr=%h want 1/14", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        checks++; if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL drain_done got v=%b req=%b addr=%h want 0/1/100", ir_valid, imem_req, imem_addr); end
        imem_rdata = 32'h0010_0093;
        tick();
        imem_ack = 1'b0;
        checks++; if (ir_valid !== 1'b1 || pc !== 32'h100 || ir !== 32'h0010_0093 || imem_addr !== 32'h104) begin errors++; $display("FAIL redir_first got v=%b pc=%h ir=%h addr=%h want 1/100/00100093/104", ir_valid, pc, ir, imem_addr); end
    endtask

    task automatic test_redirect_with_ack();
        imem_ack = 1'b1; imem_rdata = 32'hBADB_AD13;
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        imem_ack = 1'b0; redirect = 1'b0;
        checks++; if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL redir_ack got v=%b req=%b addr=%h want 0/1/200", ir_valid, imem_req, imem_addr); end
        tick();
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL redir_ack_drop got v=%b want=0", ir_valid); end
    endtask

    task automatic test_redirect_pop_full();
        ir_ready = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h0AAA_AA37;
        tick();
        checks++; if (pc !== 32'h200 || opcode !== 7'h37 || imem_addr !== 32'h204) begin errors++; $display("FAIL fill0 got pc=%h op=%h addr=%h want 200/37/204", pc, opcode, imem_addr); end
        imem_rdata = 32'h0BBB_BB17;
        tick();
        imem_ack = 1'b0;
        checks++; if (imem_req !== 1'b0 || ir_valid !== 1'b1) begin errors++; $display("FAIL fill_full got req=%b v=%b want 0/1", imem_req, ir_valid); end
        ir_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0040;
        tick();
        redirect = 1'b0;
        checks++; if (ir_valid !== 1'b0 || ir !== 32'h0 || pc !== 32'h0) begin errors++; $display("FAIL flush_pop got v=%b ir=%h pc=%h want 0/0/0", ir_valid, ir, pc); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL idle_redir got req=%b addr=%h want 1/40", imem_req, imem_addr); end
    endtask

    task automatic test_drain_retarget();
        redirect = 1'b1; redirect_pc = 32'h0000_0080;
        tick();
        redirect_pc = 32'h0000_0095;
        tick();
        redirect = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL retarget_hold got req=%b addr=%h want 1/40", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        imem_ack = 1'b0;
        checks++; if (imem_addr !== 32'h94 || ir_valid !== 1'b0) begin errors++; $display("FAIL retarget got addr=%h v=%b want 94/0", imem_addr, ir_valid); end
    endtask

    task automatic test_wrap();
        imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC || ir_valid !== 1'b0) begin errors++; $display("FAIL wrap_target got addr=%h v=%b want fffffffc/0", imem_addr, ir_valid); end
        ir_ready = 1'b0; imem_rdata = 32'h0000_0013;
        tick();
        imem_ack = 1'b0;
        checks++; if (pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap got pc=%h addr=%h want fffffffc/0", pc, imem_addr); end
    endtask

    task automatic test_async_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL arst_req got req=%b addr=%h want 0/0", imem_req, imem_addr); end
        checks++; if (ir_valid !== 1'b0 || ir !== 32'h0 || opcode !== 7'h0 || pc !== 32'h0) begin errors++; $display("FAIL arst_head got v=%b ir=%h op=%h pc=%h want 0", ir_valid, ir, opcode, pc); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || ir_valid !== 1'b0) begin errors++; $display("FAIL arst_restart got req=%b addr=%h v=%b want 1/0/0", imem_req, imem_addr, ir_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_with_ack();
        test_redirect_pop_full();
        test_drain_retarget();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
